reg_file_sb: RTL

Parametrised register file for the RISC-V pipeline: 2^ADDR_WIDTH × DATA_WIDTH registers, NUM_READ combinational read ports, two write ports (writeback and late-load) and an integrated pending-write scoreboard. Sits between decode (read, allocate) and writeback (write, release). It replaces the fixed 32×32, single-write register file. Same-cycle write-to-read bypass and per-read busy flags let the hazard unit stall without a separate scoreboard.

---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/reg_file_scoreboard.sv | 43 ++++
 rtl/reg_file_sb.sv | 89 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file with integrated scoreboard.
// Helpers work on maximum-sized vectors so any legal parametrisation can cast in and out.
package reg_file_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 2;

  localparam int MAX_ADDR_WIDTH = 8;
  localparam int MAX_NUM_READ   = 4;
  localparam int MAX_DEPTH      = 1 << MAX_ADDR_WIDTH;
  localparam int COUNT_WIDTH    = MAX_ADDR_WIDTH + 1;
  localparam int READ_BUS_WIDTH = MAX_NUM_READ * MAX_ADDR_WIDTH;

  // Extracts read port 'port' from a packed index bus whose slices are 'width' bits wide.
  function automatic logic [MAX_ADDR_WIDTH-1:0] read_slice(
    input logic [READ_BUS_WIDTH-1:0] bus,
    input int                        port,
    input int                        width
  );
    logic [READ_BUS_WIDTH-1:0] shifted;
    shifted = bus >> (port * width);
    return shifted[MAX_ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + COUNT_WIDTH'(vec[i]);
    end
    return cnt;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on allocate, cleared on write.
// Allocation beats a same-cycle release since the newly issued producer supersedes the old one.
module reg_file_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rel1_en,
  input  logic [ADDR_WIDTH-1:0]      rel1_reg,
  input  logic                       rel2_en,
  input  logic [ADDR_WIDTH-1:0]      rel2_reg,
  input  logic                       alloc_en,
  input  logic [ADDR_WIDTH-1:0]      alloc_reg,
  output logic [(1<<ADDR_WIDTH)-1:0] pending,
  output logic [ADDR_WIDTH:0]        pending_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]    pending_d, pending_q;
  logic [ADDR_WIDTH:0] count_d, count_q;

  always_comb begin
    pending_d = pending_q;
    if (rel1_en) pending_d[rel1_reg] = 1'b0;
    if (rel2_en) pending_d[rel2_reg] = 1'b0;
    if (alloc_en && !(ZERO_REG != 0 && alloc_reg == '0)) pending_d[alloc_reg] = 1'b1;
    count_d = (ADDR_WIDTH+1)'(popcount(MAX_DEPTH'(pending_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending       = pending_q;
  assign pending_count = count_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two write ports, bypassed combinational reads and per-read busy flags.
// Port 2 (late load) wins write collisions; outputs are forced to zero while RESET is high.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ,
  parameter int ZERO_REG   = 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           WRITEENABLE1,
  input  logic [ADDR_WIDTH-1:0]          WRITEREG1,
  input  logic [DATA_WIDTH-1:0]          WRITEDATA1,
  input  logic                           WRITEENABLE2,
  input  logic [ADDR_WIDTH-1:0]          WRITEREG2,
  input  logic [DATA_WIDTH-1:0]          WRITEDATA2,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] READREG,
  output logic [NUM_READ*DATA_WIDTH-1:0] REGOUT,
  output logic [NUM_READ-1:0]            BUSY,
  input  logic                           ALLOCENABLE,
  input  logic [ADDR_WIDTH-1:0]          ALLOCREG,
  output logic [ADDR_WIDTH:0]            PENDINGCOUNT
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  we1, we2;
  logic [DEPTH-1:0]      pending;
  logic [ADDR_WIDTH:0]   pending_count;

  // Writes to a hardwired x0 vanish here, so neither storage, bypass nor scoreboard sees them.
  assign we1 = WRITEENABLE1 && !(ZERO_REG != 0 && WRITEREG1 == '0);
  assign we2 = WRITEENABLE2 && !(ZERO_REG != 0 && WRITEREG2 == '0);

  always_comb begin
    regs_d = regs_q;
    if (we1) regs_d[WRITEREG1] = WRITEDATA1;
    if (we2) regs_d[WRITEREG2] = WRITEDATA2;
  end

  always_ff @(posedge CLK) begin
    if (RESET) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk           (CLK),
    .rst           (RESET),
    .rel1_en       (we1),
    .rel1_reg      (WRITEREG1),
    .rel2_en       (we2),
    .rel2_reg      (WRITEREG2),
    .alloc_en      (ALLOCENABLE),
    .alloc_reg     (ALLOCREG),
    .pending       (pending),
    .pending_count (pending_count)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] dat;
    logic                  bsy, hit1, hit2;

    assign idx  = ADDR_WIDTH'(read_slice(READ_BUS_WIDTH'(READREG), k, ADDR_WIDTH));
    assign hit1 = we1 && (WRITEREG1 == idx);
    assign hit2 = we2 && (WRITEREG2 == idx);

    always_comb begin
      dat = '0;
      bsy = 1'b0;
      if (!RESET && !(ZERO_REG != 0 && idx == '0)) begin
        if (hit2)      dat = WRITEDATA2;
        else if (hit1) dat = WRITEDATA1;
        else           dat = regs_q[idx];
        // A write presented this cycle releases the operand immediately.
        bsy = pending[idx] && !hit1 && !hit2;
      end
    end

    assign REGOUT[k*DATA_WIDTH +: DATA_WIDTH] = dat;
    assign BUSY[k] = bsy;
  end

  assign PENDINGCOUNT = RESET ? '0 : pending_count;
endmodule
